blk_mem_sp_be: RTL and testbench

Parametrised single-port block RAM with per-byte write enables, selectable output register and selectable read-during-write mode.
Includes a built-in zero-initialisation sweep after reset, so contents are deterministic without a vendor init file.
Replaces fixed 32x256 vendor-generated memory instances in SoC peripherals and local scratchpads; infers BRAM.

---
 rtl/blk_mem_pkg.sv | 21 ++
 rtl/blk_mem_init_ctrl.sv | 58 +++++
 rtl/blk_mem_sp_be.sv | 150 +++++++++++++++
 tb/tb_blk_mem_sp_be.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/blk_mem_pkg.sv
// Shared types and helpers for the byte-enabled single-port block RAM.
// Covers the write-mode encodings, the init FSM states and the per-byte merge.
package blk_mem_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/blk_mem_init_ctrl.sv
// Post-reset zero sweep for blk_mem_sp_be.
// Drives one word write per cycle while busy, from address 0 up to DEPTH-1.
module blk_mem_init_ctrl
    import blk_mem_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DEPTH         = 256,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clka,
    input  logic              rsta,
    output logic              busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    localparam init_state_e       RESET_STATE = (INIT_ON_RESET != 0) ? INIT : READY;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

    init_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        init_we   = 1'b0;
        init_addr = cnt_q;
        case (state_q)
            INIT: begin
                busy    = 1'b1;
                init_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

endmodule

// File: rtl/blk_mem_sp_be.sv
// Single-port block RAM with byte write enables, optional output register,
// selectable read-during-write behaviour and a built-in zero sweep after reset.
module blk_mem_sp_be
    import blk_mem_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 8,
    parameter int DEPTH         = 256,
    parameter int OUT_REG       = 0,
    parameter int WRITE_MODE    = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                clka,
    input  logic                rsta,
    input  logic                ena,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dina,
    output logic [DATA_W-1:0]   douta,
    output logic                dvalid,
    output logic                busy
);

    localparam int NB       = DATA_W / 8;
    localparam bit WR_FIRST = (WRITE_MODE == WM_WRITE_FIRST);

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("blk_mem_sp_be: DATA_W must be a multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("blk_mem_sp_be: DEPTH must be in 1..2**ADDR_W");
    end

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    blk_mem_init_ctrl #(
        .ADDR_W        (ADDR_W),
        .DEPTH         (DEPTH),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_init (
        .clka      (clka),
        .rsta      (rsta),
        .busy      (busy),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    logic              acc;
    logic              in_range;
    logic              rd_en;
    logic [NB-1:0]     wr_be;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // The sweep owns the write port while busy; user accesses are dropped then.
    always_comb begin
        acc      = ena & ~busy;
        in_range = (32'(addra) < 32'(DEPTH));
        rd_en    = acc & in_range;
        if (busy) begin
            wr_be   = {NB{init_we}};
            wr_addr = init_addr;
            wr_data = '0;
        end else begin
            wr_be   = rd_en ? wea : '0;
            wr_addr = addra;
            wr_data = dina;
        end
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word_q;

    // Array, byte writes and the registered read share one process so the
    // tools can map it onto block RAM; the read register has no reset.
    always_ff @(posedge clka) begin
        for (int i = 0; i < NB; i++) begin
            if (rd_en) begin
                rd_word_q[8*i +: 8] <= byte_merge(mem[addra][8*i +: 8], dina[8*i +: 8],
                                                  WR_FIRST && wea[i]);
            end
            if (wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    logic              v1_q, v1_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] s1_data;

    always_comb begin
        v1_d    = acc;
        oor_d   = acc ? ~in_range : oor_q;
        s1_data = oor_q ? '0 : rd_word_q;
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            v1_q  <= 1'b0;
            oor_q <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            oor_q <= oor_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] dout_q, dout_d;
        logic              dv_q, dv_d;

        always_comb begin
            dout_d = v1_q ? s1_data : dout_q;
            dv_d   = v1_q;
        end

        always_ff @(posedge clka or posedge rsta) begin
            if (rsta) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else begin
                dout_q <= dout_d;
                dv_q   <= dv_d;
            end
        end

        assign douta  = dout_q;
        assign dvalid = dv_q;
    end else begin : g_out_comb
        // Holds the last result so douta is stable between accesses.
        logic [DATA_W-1:0] hold_q, hold_d;

        always_comb begin
            hold_d = v1_q ? s1_data : hold_q;
        end

        always_ff @(posedge clka or posedge rsta) begin
            if (rsta) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_d;
            end
        end

        assign douta  = hold_d;
        assign dvalid = v1_q;
    end

endmodule

// File: tb/tb_blk_mem_sp_be.sv
// Directed bench for blk_mem_sp_be: instance a uses defaults, instance b has
// DEPTH=200, OUT_REG=1 and WRITE_FIRST.
module tb_blk_mem_sp_be;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        ena    [2];
    logic [3:0]  wea    [2];
    logic [7:0]  addra  [2];
    logic [31:0] dina   [2];
    logic [31:0] douta  [2];
    logic        dvalid [2];
    logic        busy   [2];

    int n_chk  = 0;
    int n_pass = 0;
    int lat [2] = '{1, 2};

    blk_mem_sp_be u_a (
        .clka   (clk),
        .rsta   (rst[0]),
        .ena    (ena[0]),
        .wea    (wea[0]),
        .addra  (addra[0]),
        .dina   (dina[0]),
        .douta  (douta[0]),
        .dvalid (dvalid[0]),
        .busy   (busy[0])
    );

    blk_mem_sp_be #(
        .DEPTH      (200),
        .OUT_REG    (1),
        .WRITE_MODE (1)
    ) u_b (
        .clka   (clk),
        .rsta   (rst[1]),
        .ena    (ena[1]),
        .wea    (wea[1]),
        .addra  (addra[1]),
        .dina   (dina[1]),
        .douta  (douta[1]),
        .dvalid (dvalid[1]),
        .busy   (busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h, want %08h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [3:0] w, input logic [7:0] a,
                         input logic [31:0] d);
        ena[s]   = 1'b1;
        wea[s]   = w;
        addra[s] = a;
        dina[s]  = d;
    endtask

    task automatic idle(input int s);
        ena[s] = 1'b0;
        wea[s] = 4'h0;
    endtask

    task automatic acc_chk(input int s, input logic [3:0] w, input logic [7:0] a,
                           input logic [31:0] d, input logic [31:0] exp, input string tag);
        drive(s, w, a, d);
        cyc();
        idle(s);
        repeat (lat[s] - 1) cyc();
        chk(tag, douta[s], exp);
        chk({tag, "_dv"}, {31'd0, dvalid[s]}, 32'd1);
    endtask

    task automatic sweep_wait(input int s, input bit poke, output int n, output bit dv);
        n  = 0;
        dv = 1'b0;
        while (busy[s] && n < 1000) begin
            cyc();
            n++;
            dv = dv | dvalid[s];
            if (poke && n == 150) drive(s, 4'hF, 8'd7, 32'h7777_7777);
            if (poke && n == 151) idle(s);
        end
    endtask

    task automatic init_run(input int s, input int depth, input string tag);
        int n;
        bit dv;
        rst[s] = 1'b1;
        repeat (2) cyc();
        chk({tag, "_rst_busy"}, {31'd0, busy[s]}, 32'd1);
        chk({tag, "_rst_dv"}, {31'd0, dvalid[s]}, 32'd0);
        chk({tag, "_rst_dout"}, douta[s], 32'd0);
        drive(s, 4'h0, 8'd5, 32'd0);
        rst[s] = 1'b0;
        sweep_wait(s, 1'b0, n, dv);
        chk({tag, "_busy_cycles"}, n, depth);
        chk({tag, "_dv_in_sweep"}, {31'd0, dv}, 32'd0);
        repeat (lat[s]) cyc();
        chk({tag, "_first_rd_dv"}, {31'd0, dvalid[s]}, 32'd1);
        chk({tag, "_first_rd"}, douta[s], 32'd0);
        idle(s);
        repeat (3) cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit dv;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1;
            idle(s);
            addra[s] = 8'd0;
            dina[s]  = 32'd0;
        end
        cyc();

        init_run(0, 256, "t1a");
        init_run(1, 200, "t1b");

        acc_chk(0, 4'hF, 8'h10, 32'hAABB_CCDD, 32'h0000_0000, "t2_wr_full");
        acc_chk(0, 4'h5, 8'h10, 32'h1122_3344, 32'hAABB_CCDD, "t2_wr_part");
        acc_chk(0, 4'h0, 8'h10, 32'h0, 32'hAA22_CC44, "t2_rd");
        cyc();
        chk("t2_hold_dv", {31'd0, dvalid[0]}, 32'd0);
        chk("t2_hold_dout", douta[0], 32'hAA22_CC44);

        acc_chk(0, 4'hF, 8'd3, 32'h1234_5678, 32'h0000_0000, "t3a_wr0");
        acc_chk(0, 4'hF, 8'd3, 32'hDEAD_BEEF, 32'h1234_5678, "t3a_rf");
        acc_chk(0, 4'h0, 8'd3, 32'h0, 32'hDEAD_BEEF, "t3a_rd");
        acc_chk(1, 4'hF, 8'd3, 32'h1234_5678, 32'h1234_5678, "t3b_wr0");
        acc_chk(1, 4'hF, 8'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "t3b_wf");
        acc_chk(1, 4'h3, 8'd3, 32'h5555_5555, 32'hDEAD_5555, "t3b_wf_part");
        acc_chk(1, 4'h0, 8'd3, 32'h0, 32'hDEAD_5555, "t3b_rd");

        for (int i = 0; i < 32; i++) begin
            drive(1, 4'hF, 8'(i), 32'(i * 3));
            cyc();
        end
        idle(1);
        repeat (3) cyc();
        for (int k = 0; k < 34; k++) begin
            if (k < 32) drive(1, 4'h0, 8'(k), 32'd0);
            else idle(1);
            cyc();
            chk($sformatf("t4_dv_%0d", k), {31'd0, dvalid[1]}, (k >= 1 && k <= 32) ? 32'd1 : 32'd0);
            if (k >= 1 && k <= 32) chk($sformatf("t4_rd_%0d", k - 1), douta[1], 32'((k - 1) * 3));
        end
        idle(1);
        repeat (3) cyc();

        acc_chk(0, 4'hF, 8'd200, 32'h5A5A_5A5A, 32'h0, "t5_wr200");
        acc_chk(0, 4'h0, 8'd200, 32'h0, 32'h5A5A_5A5A, "t5_rd200_pre");
        rst[0] = 1'b1;
        cyc();
        rst[0] = 1'b0;
        repeat (100) cyc();
        chk("t5_busy_at_100", {31'd0, busy[0]}, 32'd1);
        rst[0] = 1'b1;
        cyc();
        rst[0] = 1'b0;
        sweep_wait(0, 1'b1, n, dv);
        chk("t5_busy_cycles", n, 256);
        chk("t5_dv_in_sweep", {31'd0, dv}, 32'd0);
        acc_chk(0, 4'h0, 8'd200, 32'h0, 32'h0, "t5_rd200_post");
        acc_chk(0, 4'h0, 8'd7, 32'h0, 32'h0, "t5_rd7_dropped_wr");

        acc_chk(1, 4'h0, 8'd199, 32'h0, 32'h0, "t6_rd199_init");
        acc_chk(1, 4'hF, 8'd220, 32'hFFFF_FFFF, 32'h0, "t6_wr_oor");
        acc_chk(1, 4'h0, 8'd220, 32'h0, 32'h0, "t6_rd_oor");
        acc_chk(1, 4'h0, 8'd20, 32'h0, 32'd60, "t6_rd20_no_alias");
        acc_chk(1, 4'hF, 8'd199, 32'hCAFE_F00D, 32'hCAFE_F00D, "t6_wr199");
        acc_chk(1, 4'h0, 8'd199, 32'h0, 32'hCAFE_F00D, "t6_rd199");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
